// File: rtl/shift_tx.sv
// shift_tx: parallel-in, serial-out transmitter with a capture strobe.
//
// A word accepted on data_in (load && ready) is sent MSB first on out, each
// bit held for DIV clock cycles. sel is high for exactly one cycle per bit,
// in the last cycle of that bit, so a downstream register clocked on the
// same edge captures the bit before out moves on. done pulses for one cycle
// after the last bit's strobe; ready is already high in that cycle, so a new
// load can follow with no gap.
//
// Ports:
//   clk     - clock, all state changes on rising edge
//   rst     - asynchronous active-high reset
//   data_in - WIDTH-bit word, sampled only when load && ready
//   load    - start request (ignored while busy)
//   ready   - idle, can accept a word
//   out     - registered serial data, MSB first, 0 when idle
//   sel     - capture strobe, one cycle per bit
//   busy    - transfer in progress
//   done    - one-cycle pulse after the last bit's strobe
module shift_tx #(
  parameter int WIDTH = 8,   // bits per word, 1..32
  parameter int DIV   = 4    // clock cycles per serial bit, 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             sel,
  output logic             busy,
  output logic             done
);

  // Counters need at least one bit even when DIV or WIDTH is 1.
  localparam int CW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_sh;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             start;
  logic             last;

  // Strobe decodes registered state only, so it never glitches on inputs.
  assign sel      = (state == SHIFT) && (div_cnt == CW'(DIV - 1));
  assign last     = sel && (bit_cnt == BW'(WIDTH - 1));
  assign start    = (state == IDLE) && load;
  // Shifted copy: its MSB is the next bit to present. Works for WIDTH=1
  // without an out-of-range index.
  assign shreg_sh = shreg << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      out     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg   <= data_in;
        div_cnt <= '0;
        bit_cnt <= '0;
        out     <= data_in[WIDTH-1];
      end else if (state == SHIFT) begin
        div_cnt <= sel ? '0 : div_cnt + 1'b1;
        if (sel) begin
          if (last) begin
            shreg <= '0;
            out   <= 1'b0;
            done  <= 1'b1;
          end else begin
            shreg   <= shreg_sh;
            out     <= shreg_sh[WIDTH-1];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx: default instance (WIDTH=8, DIV=4) plus a WIDTH=4,
// DIV=1 instance. Expected bits go into a queue when a word is loaded and
// are popped against out on every sel cycle; a capture chain rebuilds words.
module tb_shift_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load;
  logic       ready, out, sel, busy, done;

  logic [3:0] d1_data;
  logic       d1_load;
  logic       d1_ready, d1_out, d1_sel, d1_busy, d1_done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit exp1_q[$];

  shift_tx u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready), .out(out), .sel(sel), .busy(busy), .done(done)
  );

  shift_tx #(.WIDTH(4), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(d1_data), .load(d1_load),
    .ready(d1_ready), .out(d1_out), .sel(d1_sel), .busy(d1_busy), .done(d1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; data_in = 8'h00; d1_load = 1'b0; d1_data = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, busy, out, sel, done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/busy/out/sel/done=%b want 10000",
               {ready, busy, out, sel, done});
    end
    checks++;
    if ({d1_ready, d1_busy, d1_out, d1_sel, d1_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs_div1: got %b want 10000",
               {d1_ready, d1_busy, d1_out, d1_sel, d1_done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Full single-word transfer with cycle-by-cycle checks against the
  // expected timeline (sel at cycles 4,8..32, done at 33).
  task automatic xfer_word(input logic [7:0] w, input string tag);
    logic [7:0] cap;
    bit         e;
    logic       exp_out;
    cap = '0;
    data_in = w; load = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) load = 1'b0;
      exp_out = (n <= 32) ? w[7 - (n - 1) / 4] : 1'b0;
      checks++;
      if (sel !== ((n % 4 == 0) && (n <= 32))) begin
        errors++; $display("FAIL %s_sel: cycle %0d got %b", tag, n, sel);
      end
      checks++;
      if (out !== exp_out) begin
        errors++; $display("FAIL %s_out: cycle %0d got %b want %b", tag, n, out, exp_out);
      end
      if (sel === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_sb: unexpected strobe at cycle %0d", tag, n);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            errors++; $display("FAIL %s_sb: cycle %0d got %b want %b", tag, n, out, e);
          end
        end
        cap = {cap[6:0], out};
      end
      checks++;
      if (done !== (n == 33)) begin
        errors++; $display("FAIL %s_done: cycle %0d got %b", tag, n, done);
      end
      checks++;
      if ({ready, busy} !== ((n <= 32) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL %s_rdy_busy: cycle %0d got %b", tag, n, {ready, busy});
      end
    end
    checks++;
    if (cap !== w || exp_q.size() != 0) begin
      errors++; $display("FAIL %s_capture: got %h want %h (left %0d)", tag, cap, w, exp_q.size());
    end
  endtask

  task automatic test_basic();
    xfer_word(8'hA5, "basic");
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap;
    int          nsel, ndone;
    bit          e, exp_sel, exp_done, exp_busy;
    logic        exp_out;
    logic [7:0]  w0, w1;
    w0 = 8'h3C; w1 = 8'hC3; cap = '0; nsel = 0; ndone = 0;
    data_in = w0; load = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w0[i]);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      exp_sel  = ((n <= 32) && (n % 4 == 0)) || ((n >= 37) && (n <= 65) && ((n - 33) % 4 == 0));
      exp_done = (n == 33) || (n == 66);
      exp_busy = (n != 33) && (n <= 65);
      if (n <= 32)                 exp_out = w0[7 - (n - 1) / 4];
      else if (n >= 34 && n <= 65) exp_out = w1[7 - (n - 34) / 4];
      else                         exp_out = 1'b0;
      checks++;
      if ({sel, done, busy, out} !== {exp_sel, exp_done, exp_busy, exp_out}) begin
        errors++;
        $display("FAIL b2b_cycle: cycle %0d sel/done/busy/out got %b want %b",
                 n, {sel, done, busy, out}, {exp_sel, exp_done, exp_busy, exp_out});
      end
      if (sel === 1'b1) begin
        nsel++;
        cap = {cap[14:0], out};
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if (out !== e) begin
            errors++; $display("FAIL b2b_sb: cycle %0d got %b want %b", n, out, e);
          end
        end
      end
      if (done === 1'b1) ndone++;
      if (n == 1)  load = 1'b0;
      if (n == 33) begin
        data_in = w1; load = 1'b1;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w1[i]);
      end
      if (n == 34) load = 1'b0;
    end
    checks++;
    if (nsel != 16 || ndone != 2) begin
      errors++; $display("FAIL b2b_counts: sel %0d want 16, done %0d want 2", nsel, ndone);
    end
    checks++;
    if (cap !== 16'h3CC3) begin
      errors++; $display("FAIL b2b_capture: got %h want 3cc3", cap);
    end
  endtask

  task automatic test_load_while_busy();
    logic [7:0] cap;
    int         ndone;
    bit         e;
    cap = 8'hFF; ndone = 0;
    data_in = 8'h00; load = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      checks++;
      if (out !== 1'b0) begin
        errors++; $display("FAIL busy_load_out: cycle %0d got %b want 0", n, out);
      end
      if (sel === 1'b1) begin
        cap = {cap[6:0], out};
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if (out !== e) begin
            errors++; $display("FAIL busy_load_sb: cycle %0d got %b want %b", n, out, e);
          end
        end
      end
      if (done === 1'b1) ndone++;
      if (n == 1)  load = 1'b0;
      if (n == 10) begin data_in = 8'hFF; load = 1'b1; end
      if (n == 11) load = 1'b0;
    end
    checks++;
    if (cap !== 8'h00 || ndone != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL busy_load_result: cap %h want 00, done %0d want 1", cap, ndone);
    end
  endtask

  task automatic test_reset_mid();
    data_in = 8'h5A; load = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == 1) load = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, busy, out, sel, done} !== 5'b10000) begin
      errors++; $display("FAIL rst_mid_async: got %b want 10000", {ready, busy, out, sel, done});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      checks++;
      if ({ready, busy, out, sel, done} !== 5'b10000) begin
        errors++; $display("FAIL rst_mid_idle: cycle %0d got %b want 10000", n, {ready, busy, out, sel, done});
      end
    end
    xfer_word(8'h81, "post_rst");
  endtask

  task automatic test_div1();
    bit   e;
    logic exp_out;
    logic [3:0] w;
    w = 4'h9;
    @(negedge clk);
    d1_data = w; d1_load = 1'b1;
    for (int i = 3; i >= 0; i--) exp1_q.push_back(w[i]);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) d1_load = 1'b0;
      exp_out = (n <= 4) ? w[4 - n] : 1'b0;
      checks++;
      if ({d1_sel, d1_done, d1_out} !== {(n <= 4), (n == 5), exp_out}) begin
        errors++;
        $display("FAIL div1_cycle: cycle %0d sel/done/out got %b want %b",
                 n, {d1_sel, d1_done, d1_out}, {(n <= 4), (n == 5), exp_out});
      end
      if (d1_sel === 1'b1) begin
        checks++;
        if (exp1_q.size() == 0) begin
          errors++; $display("FAIL div1_sb: unexpected strobe at cycle %0d", n);
        end else begin
          e = exp1_q.pop_front();
          if (d1_out !== e) begin
            errors++; $display("FAIL div1_sb: cycle %0d got %b want %b", n, d1_out, e);
          end
        end
      end
    end
    checks++;
    if (exp1_q.size() != 0) begin
      errors++; $display("FAIL div1_drain: %0d bits not sent", exp1_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
